dpsram_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences the dual-port SRAM as a circular buffer: port 1 is the dedicated write port, port 2 the dedicated read port. It owns the write/read pointers, occupancy count and full/empty flags, gates requests against them, and returns read data with a one-cycle valid strobe aligned to the SRAM's registered output. It sits between the FIFO user logic and the dual-port SRAM instance in the FIFO top level.

---
 rtl/dpsram_fifo_ctrl_if.sv | 47 ++++
 rtl/dpsram_fifo_ctrl.sv | 79 +++++++
 tb/tb_dpsram_fifo_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dpsram_fifo_ctrl_if.sv
// User-side and SRAM-side signal bundle of the dual-port SRAM FIFO controller.
// Error flag signals exist only when FIFO_ERR_FLAGS_EN is defined.
interface dpsram_fifo_ctrl_if #(
  parameter int unsigned a_length = 3,
  parameter int unsigned d_length = 8
);
  logic                wr_en;
  logic [d_length-1:0] wr_data;
  logic                rd_en;
  logic [d_length-1:0] rd_data;
  logic                rd_valid;
  logic                full;
  logic                empty;
  logic [a_length:0]   count;
  logic                mem_en_p1;
  logic                mem_ctrl_p1;
  logic [a_length-1:0] mem_addr_p1;
  logic [d_length-1:0] mem_din_p1;
  logic                mem_en_p2;
  logic                mem_ctrl_p2;
  logic [a_length-1:0] mem_addr_p2;
  logic [d_length-1:0] mem_dout_p2;
`ifdef FIFO_ERR_FLAGS_EN
  logic                overflow;
  logic                underflow;
`endif

  modport master (
    output wr_en, wr_data, rd_en, mem_dout_p2,
    input  rd_data, rd_valid, full, empty, count,
    input  mem_en_p1, mem_ctrl_p1, mem_addr_p1, mem_din_p1,
    input  mem_en_p2, mem_ctrl_p2, mem_addr_p2
`ifdef FIFO_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  wr_en, wr_data, rd_en, mem_dout_p2,
    output rd_data, rd_valid, full, empty, count,
    output mem_en_p1, mem_ctrl_p1, mem_addr_p1, mem_din_p1,
    output mem_en_p2, mem_ctrl_p2, mem_addr_p2
`ifdef FIFO_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/dpsram_fifo_ctrl.sv
// Circular-buffer controller for a dual-port SRAM: port 1 writes, port 2 reads.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module dpsram_fifo_ctrl #(
  parameter int unsigned a_length     = 3,
  parameter int unsigned d_length     = 8,
  parameter int unsigned config_depth = 8
) (
  input logic               clk,
  input logic               rst,
  dpsram_fifo_ctrl_if.slave bus
);
  localparam int unsigned PtrW = a_length + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] count;
  logic            rd_valid_q;
  logic            full;
  logic            empty;
  logic            wr_acc;
  logic            rd_acc;

  // Modular difference of the extended pointers gives 0..config_depth directly.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (count == PtrW'(config_depth));

  always_comb begin
    wr_acc   = bus.wr_en & ~full & ~rst;
    rd_acc   = bus.rd_en & ~empty & ~rst;
    wr_ptr_d = wr_ptr_q + PtrW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PtrW'(rd_acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_acc;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full)  overflow_q  <= 1'b1;
      if (bus.rd_en && empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

  always_comb begin
    bus.count       = count;
    bus.full        = full;
    bus.empty       = empty;
    bus.rd_valid    = rd_valid_q;
    bus.rd_data     = bus.mem_dout_p2;
    bus.mem_en_p1   = wr_acc;
    bus.mem_ctrl_p1 = 1'b1;
    bus.mem_addr_p1 = wr_ptr_q[a_length-1:0];
    bus.mem_din_p1  = bus.wr_data;
    bus.mem_en_p2   = rd_acc;
    bus.mem_ctrl_p2 = 1'b0;
    bus.mem_addr_p2 = rd_ptr_q[a_length-1:0];
  end
endmodule

// File: tb/tb_dpsram_fifo_ctrl.sv
// Bench for dpsram_fifo_ctrl: directed table, corner sequences and random traffic
// against a queue-based model, with a behavioural dual-port SRAM attached.
module tb_dpsram_fifo_ctrl;
  localparam int unsigned AL    = 3;
  localparam int unsigned DL    = 8;
  localparam int unsigned Depth = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpsram_fifo_ctrl_if #(.a_length(AL), .d_length(DL)) bus ();

  dpsram_fifo_ctrl #(
    .a_length    (AL),
    .d_length    (DL),
    .config_depth(Depth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Behavioural SRAM with registered read port.
  logic [DL-1:0] mem [Depth];
  always @(posedge clk) begin
    if (bus.mem_en_p1 && bus.mem_ctrl_p1) mem[bus.mem_addr_p1] <= bus.mem_din_p1;
    if (bus.mem_en_p2 && !bus.mem_ctrl_p2) bus.mem_dout_p2 <= mem[bus.mem_addr_p2];
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents as a queue, pointers as totals of accepted ops.
  logic [DL-1:0] q[$];
  int            wr_tot, rd_tot;
  bit            exp_valid;
  logic [DL-1:0] exp_data;
  bit            exp_ovf, exp_unf;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wr_tot = 0;
    rd_tot = 0;
    exp_valid = 0;
    exp_data = '0;
    exp_ovf = 0;
    exp_unf = 0;
  endtask

  // One clock cycle of traffic, entered and left just after a falling edge.
  task automatic cycle(input bit we, input bit re, input logic [DL-1:0] d,
                       output bit s_en1, output bit s_en2);
    bit full_m, empty_m;
    bus.wr_en = we;
    bus.rd_en = re;
    bus.wr_data = d;
    #1;
    full_m  = (q.size() == Depth);
    empty_m = (q.size() == 0);
    s_en1 = bus.mem_en_p1;
    s_en2 = bus.mem_en_p2;
    chk("count", int'(bus.count), q.size());
    chk("full", int'(bus.full), int'(full_m));
    chk("empty", int'(bus.empty), int'(empty_m));
    chk("mem_en_p1", int'(bus.mem_en_p1), int'(we && !full_m));
    chk("mem_en_p2", int'(bus.mem_en_p2), int'(re && !empty_m));
    chk("mem_ctrl_p1", int'(bus.mem_ctrl_p1), 1);
    chk("mem_ctrl_p2", int'(bus.mem_ctrl_p2), 0);
    if (we && !full_m) begin
      chk("mem_addr_p1", int'(bus.mem_addr_p1), wr_tot % Depth);
      chk("mem_din_p1", int'(bus.mem_din_p1), int'(d));
    end
    if (re && !empty_m) chk("mem_addr_p2", int'(bus.mem_addr_p2), rd_tot % Depth);
    chk("rd_valid", int'(bus.rd_valid), int'(exp_valid));
    if (exp_valid) chk("rd_data", int'(bus.rd_data), int'(exp_data));
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", int'(bus.overflow), int'(exp_ovf));
    chk("underflow", int'(bus.underflow), int'(exp_unf));
`endif
    @(posedge clk);
    if (we && full_m) exp_ovf = 1;
    if (re && empty_m) exp_unf = 1;
    exp_valid = 0;
    if (re && !empty_m) begin
      exp_data = q.pop_front();
      exp_valid = 1;
      rd_tot++;
    end
    if (we && !full_m) begin
      q.push_back(d);
      wr_tot++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit            we;
    bit            re;
    logic [DL-1:0] d;
    bit            en1;
    bit            en2;
    int            cnt_after;
    bit            full_after;
    bit            empty_after;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e1, e2;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    model_reset();

    // Fill 0x11..0x18, overflow attempt, then read+write at full, drain, empty corners.
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1, 0, 8'(8'h11 + i), 1, 0, i + 1, i == 7, 0});
    vecs.push_back('{1, 0, 8'h99, 0, 0, 8, 1, 0});
    vecs.push_back('{1, 1, 8'hAA, 0, 1, 7, 0, 0});
    for (int i = 0; i < 7; i++)
      vecs.push_back('{0, 1, 8'h00, 0, 1, 6 - i, 0, i == 6});
    vecs.push_back('{0, 1, 8'h00, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 8'h55, 1, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 8'h56, 1, 0, 2, 0, 0});
    vecs.push_back('{1, 0, 8'h57, 1, 0, 3, 0, 0});
    vecs.push_back('{1, 1, 8'h58, 1, 1, 3, 0, 0});

    // Reset state while rst is held.
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    #1;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_mem_en_p1", int'(bus.mem_en_p1), 0);
    chk("rst_mem_en_p2", int'(bus.mem_en_p2), 0);
    do_reset();

    foreach (vecs[i]) begin
      cycle(vecs[i].we, vecs[i].re, vecs[i].d, e1, e2);
      chk($sformatf("vec%0d_en1", i), int'(e1), int'(vecs[i].en1));
      chk($sformatf("vec%0d_en2", i), int'(e2), int'(vecs[i].en2));
      chk($sformatf("vec%0d_count", i), int'(bus.count), vecs[i].cnt_after);
      chk($sformatf("vec%0d_full", i), int'(bus.full), int'(vecs[i].full_after));
      chk($sformatf("vec%0d_empty", i), int'(bus.empty), int'(vecs[i].empty_after));
    end
    cycle(0, 0, 8'h00, e1, e2);

    // Interleaved write/read of 20 words: wraps pointers, never fills.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 8'(8'h30 + i), e1, e2);
      cycle(0, 1, 8'h00, e1, e2);
      chk("interleave_full", int'(bus.full), 0);
    end
    cycle(0, 0, 8'h00, e1, e2);

    // Underflow is sticky until reset.
    cycle(0, 1, 8'h00, e1, e2);
    cycle(1, 0, 8'h71, e1, e2);
    cycle(0, 1, 8'h00, e1, e2);
    cycle(0, 0, 8'h00, e1, e2);

    // Reset mid-stream with count=5 and a read in flight.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'hC0 + i), e1, e2);
    cycle(0, 1, 8'h00, e1, e2);
    chk("inflight_rd_valid", int'(bus.rd_valid), 1);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_rd_valid", int'(bus.rd_valid), 0);
    chk("arst_count", int'(bus.count), 0);
    chk("arst_empty", int'(bus.empty), 1);
    chk("arst_full", int'(bus.full), 0);
    chk("arst_mem_en_p1", int'(bus.mem_en_p1), 0);
    chk("arst_mem_en_p2", int'(bus.mem_en_p2), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("arst_underflow", int'(bus.underflow), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(0, 0, 8'h00, e1, e2);

    // Random traffic with shifting bias to visit full and empty regularly.
    for (int blk = 0; blk < 8; blk++) begin
      int pw, pr;
      pw = (blk % 2 == 0) ? 75 : 30;
      pr = (blk % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 200; i++) begin
        bit we, re;
        we = ($urandom_range(0, 99) < pw);
        re = ($urandom_range(0, 99) < pr);
        cycle(we, re, 8'($urandom), e1, e2);
      end
    end
    cycle(0, 0, 8'h00, e1, e2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
